// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and segment ordering shared by seven-segment drivers
package seg7_pkg;

  // Segment bit positions within {a,b,c,d,e,f,g,dp}; all segments are active-low.
  typedef enum logic [2:0] {
    SEG_DP = 3'd0,
    SEG_G  = 3'd1,
    SEG_F  = 3'd2,
    SEG_E  = 3'd3,
    SEG_D  = 3'd4,
    SEG_C  = 3'd5,
    SEG_B  = 3'd6,
    SEG_A  = 3'd7
  } seg_bit_e;

  localparam int DOT_BIT = 0;

  localparam logic [7:0] GLYPH_0     = 8'b00000011;
  localparam logic [7:0] GLYPH_1     = 8'b10011111;
  localparam logic [7:0] GLYPH_2     = 8'b00100101;
  localparam logic [7:0] GLYPH_3     = 8'b00001101;
  localparam logic [7:0] GLYPH_4     = 8'b10011001;
  localparam logic [7:0] GLYPH_5     = 8'b01001001;
  localparam logic [7:0] GLYPH_6     = 8'b01000001;
  localparam logic [7:0] GLYPH_7     = 8'b00011111;
  localparam logic [7:0] GLYPH_8     = 8'b00000001;
  localparam logic [7:0] GLYPH_9     = 8'b00001001;
  localparam logic [7:0] GLYPH_A     = 8'b00010001;
  localparam logic [7:0] GLYPH_B     = 8'b11000001;
  localparam logic [7:0] GLYPH_C     = 8'b01100011;
  localparam logic [7:0] GLYPH_D     = 8'b10000101;
  localparam logic [7:0] GLYPH_E     = 8'b01100001;
  localparam logic [7:0] GLYPH_F     = 8'b01110001;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  function automatic logic [7:0] glyph_of(input logic [3:0] code);
    logic [7:0] g;
    case (code)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// rtl/seg7_glyph_decoder.sv - combinational code/dot/blank to active-low segment pattern
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dot,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [7:0] segments
);

  always_comb begin
    segments = GLYPH_BLANK;
    // Codes A..F stay dark unless hex glyphs are enabled; the dot goes dark with them.
    if (!blank && (hex_mode || code < 4'hA)) begin
      segments = glyph_of(code);
      if (dot) segments[DOT_BIT] = 1'b0;
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed common-anode scanner with PWM and frame-synchronous shadow
// Optional leading-zero suppression when LEAD_ZERO_BLANK_EN is defined.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk_8KHz,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digit,
  input  logic [N_DIGITS-1:0]   en_dot,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [N_DIGITS-1:0]   pos,
  output logic [7:0]            segments,
  output logic                  frame_start
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [BRIGHT_W-1:0]   dwell_q, dwell_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] active_digit_q, active_digit_d, pending_digit_q, pending_digit_d;
  logic [N_DIGITS-1:0]   active_dot_q, active_dot_d, pending_dot_q, pending_dot_d;
  logic [N_DIGITS-1:0]   active_blank_q, active_blank_d, pending_blank_q, pending_blank_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [N_DIGITS-1:0]   pos_q, pos_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_start_q, frame_start_d;

  logic                  wrap, boundary, lit;
  logic [3:0]            cur_code;
  logic                  cur_dot, cur_blank;
  logic [7:0]            dec_seg;
  logic [N_DIGITS-1:0]   lz_mask;

  always_comb begin
    wrap     = (dwell_q == '1);
    boundary = wrap && (idx_q == IDX_W'(N_DIGITS - 1));

    dwell_d = dwell_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) idx_d = boundary ? '0 : idx_q + 1'b1;

    active_digit_d  = active_digit_q;
    active_dot_d    = active_dot_q;
    active_blank_d  = active_blank_q;
    pending_digit_d = pending_digit_q;
    pending_dot_d   = pending_dot_q;
    pending_blank_d = pending_blank_q;
    pending_valid_d = pending_valid_q;

    if (boundary && pending_valid_q) begin
      active_digit_d  = pending_digit_q;
      active_dot_d    = pending_dot_q;
      active_blank_d  = pending_blank_q;
      pending_valid_d = 1'b0;
    end
    // A load on the boundary cycle lands in pending and waits for the next frame.
    if (load) begin
      pending_digit_d = digit;
      pending_dot_d   = en_dot;
      pending_blank_d = blank;
      pending_valid_d = 1'b1;
    end

    frame_start_d = boundary;
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_mask_q, lz_mask_d, lz_next;
  logic                lz_lead;

  always_comb begin
    lz_next = '0;
    lz_lead = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (lz_lead && active_digit_d[4*i +: 4] == 4'h0 && !active_dot_d[i]) lz_next[i] = 1'b1;
      else lz_lead = 1'b0;
    end
    lz_mask_d = boundary ? lz_next : lz_mask_q;
  end

  assign lz_mask = lz_mask_q;
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    lit       = (dwell_q < brightness);
    cur_code  = active_digit_q[4*int'(idx_q) +: 4];
    cur_dot   = active_dot_q[idx_q];
    cur_blank = active_blank_q[idx_q] | lz_mask[idx_q];
  end

  seg7_glyph_decoder u_decoder (
    .code     (cur_code),
    .dot      (cur_dot),
    .hex_mode (hex_mode),
    .blank    (cur_blank),
    .segments (dec_seg)
  );

  // Blanked digits still get their anode slot so every dwell looks identical electrically.
  always_comb begin
    pos_d = '1;
    seg_d = GLYPH_BLANK;
    if (lit) begin
      pos_d[idx_q] = 1'b0;
      seg_d        = dec_seg;
    end
  end

  always_ff @(posedge clk_8KHz) begin
    if (!rst) begin
      dwell_q         <= '0;
      idx_q           <= '0;
      active_digit_q  <= '1;
      active_dot_q    <= '0;
      active_blank_q  <= '1;
      pending_digit_q <= '1;
      pending_dot_q   <= '0;
      pending_blank_q <= '1;
      pending_valid_q <= 1'b0;
      pos_q           <= '1;
      seg_q           <= GLYPH_BLANK;
      frame_start_q   <= 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
      lz_mask_q       <= '0;
`endif
    end else begin
      dwell_q         <= dwell_d;
      idx_q           <= idx_d;
      active_digit_q  <= active_digit_d;
      active_dot_q    <= active_dot_d;
      active_blank_q  <= active_blank_d;
      pending_digit_q <= pending_digit_d;
      pending_dot_q   <= pending_dot_d;
      pending_blank_q <= pending_blank_d;
      pending_valid_q <= pending_valid_d;
      pos_q           <= pos_d;
      seg_q           <= seg_d;
      frame_start_q   <= frame_start_d;
`ifdef LEAD_ZERO_BLANK_EN
      lz_mask_q       <= lz_mask_d;
`endif
    end
  end

  assign pos         = pos_q;
  assign segments    = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - directed self-checking bench for seven_segment_scanner (8 digits, 4-bit brightness)
module tb_seven_segment_scanner;

  logic        clk_8KHz = 1'b0;
  logic        rst;
  logic [31:0] digit;
  logic [7:0]  en_dot;
  logic [7:0]  blank;
  logic        load;
  logic        hex_mode;
  logic [3:0]  brightness;
  logic [7:0]  pos;
  logic [7:0]  segments;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int lit;
  int n;
  logic [7:0] gl [0:9];
  logic [7:0] exp_pos;
  logic [7:0] exp_seg;

  always #5 clk_8KHz = ~clk_8KHz;

  seven_segment_scanner #(.N_DIGITS(8), .BRIGHT_W(4)) dut (
    .clk_8KHz    (clk_8KHz),
    .rst         (rst),
    .digit       (digit),
    .en_dot      (en_dot),
    .blank       (blank),
    .load        (load),
    .hex_mode    (hex_mode),
    .brightness  (brightness),
    .pos         (pos),
    .segments    (segments),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk_8KHz);
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (frame_start !== 1'b1 && k < 400);
    check("frame_start_wait", {31'd0, frame_start}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dt, input logic [7:0] bk);
    digit  = d;
    en_dot = dt;
    blank  = bk;
    load   = 1'b1;
    step(1);
    load   = 1'b0;
  endtask

  initial begin
    gl = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
           8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};
    rst = 1'b0; digit = '0; en_dot = '0; blank = '0; load = 1'b0;
    hex_mode = 1'b1; brightness = 4'd15;

    step(2);
    check("reset_pos", {24'd0, pos}, 32'hFF);
    check("reset_seg", {24'd0, segments}, 32'hFF);
    check("reset_fs", {31'd0, frame_start}, 32'd0);

    rst = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_start !== 1'b1 && n < 300);
    check("fs_after_reset_cycles", n, 128);

    do_load(32'h76543210, 8'h00, 8'h00);
    wait_fs();
    for (int d = 0; d < 8; d++) begin
      exp_pos = ~(8'h01 << d);
      lit = 0;
      for (int c = 0; c < 16; c++) begin
        step(1);
        if (c == 0) begin
          check($sformatf("scan_pos_d%0d", d), {24'd0, pos}, {24'd0, exp_pos});
          check($sformatf("scan_seg_d%0d", d), {24'd0, segments}, {24'd0, gl[d]});
        end
        if (pos === exp_pos) lit++;
      end
      check($sformatf("scan_lit_d%0d", d), lit, 15);
    end
    check("fs_period", {31'd0, frame_start}, 32'd1);

    do_load(32'h7654321A, 8'h00, 8'h00);
    wait_fs();
    step(1);
    check("hex_on_seg", {24'd0, segments}, 32'h11);
    check("hex_on_pos", {24'd0, pos}, 32'hFE);
    hex_mode = 1'b0;
    step(1);
    check("hex_off_seg", {24'd0, segments}, 32'hFF);
    check("hex_off_pos", {24'd0, pos}, 32'hFE);
    hex_mode = 1'b1;
    wait_fs();

    brightness = 4'd4;
    lit = 0;
    for (int c = 0; c < 16; c++) begin
      step(1);
      if (pos !== 8'hFF) lit++;
    end
    check("bright4_lit", lit, 4);
    brightness = 4'd0;
    lit = 0;
    for (int c = 0; c < 128; c++) begin
      step(1);
      if (pos !== 8'hFF) lit++;
    end
    check("bright0_lit", lit, 0);
    brightness = 4'd15;
    wait_fs();

    step(48);
    do_load(32'h11111111, 8'h00, 8'h00);
    step(31);
    do_load(32'hFEDCBA98, 8'h02, 8'h04);
    step(32);
    check("midframe_old_pos", {24'd0, pos}, 32'h7F);
    check("midframe_old_seg", {24'd0, segments}, {24'd0, gl[7]});
    wait_fs();
    step(1);
    check("lastload_d0_pos", {24'd0, pos}, 32'hFE);
    check("lastload_d0_seg", {24'd0, segments}, {24'd0, gl[8]});
    step(16);
    check("dot_d1_pos", {24'd0, pos}, 32'hFD);
    check("dot_d1_seg", {24'd0, segments}, 32'h08);
    step(16);
    check("blank_d2_pos", {24'd0, pos}, 32'hFB);
    check("blank_d2_seg", {24'd0, segments}, 32'hFF);
    wait_fs();

    do_load(32'h00000120, 8'h00, 8'h00);
    wait_fs();
    step(1);
    for (int d = 0; d < 8; d++) begin
      exp_pos = ~(8'h01 << d);
      if (d == 0) exp_seg = gl[0];
      else if (d == 1) exp_seg = gl[2];
      else if (d == 2) exp_seg = gl[1];
      else begin
`ifdef LEAD_ZERO_BLANK_EN
        exp_seg = 8'hFF;
`else
        exp_seg = gl[0];
`endif
      end
      check($sformatf("lz120_pos_d%0d", d), {24'd0, pos}, {24'd0, exp_pos});
      check($sformatf("lz120_seg_d%0d", d), {24'd0, segments}, {24'd0, exp_seg});
      step(16);
    end

    do_load(32'h00000000, 8'h00, 8'h00);
    wait_fs();
    step(1);
    for (int d = 0; d < 8; d++) begin
`ifdef LEAD_ZERO_BLANK_EN
      exp_seg = (d == 0) ? gl[0] : 8'hFF;
`else
      exp_seg = gl[0];
`endif
      check($sformatf("lz0_seg_d%0d", d), {24'd0, segments}, {24'd0, exp_seg});
      step(16);
    end

    rst = 1'b0;
    step(1);
    check("midreset_pos", {24'd0, pos}, 32'hFF);
    check("midreset_seg", {24'd0, segments}, 32'hFF);
    check("midreset_fs", {31'd0, frame_start}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
